sr_ff_checker: RTL and testbench



---
 rtl/sr_ff_pkg.sv | 39 +++
 rtl/sr_ff_checker_sat_counter.sv | 29 ++
 rtl/sr_ff_checker.sv | 93 +++++++++
 tb/tb_sr_ff_checker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ff_pkg.sv
// Shared types and helpers for the SR flip-flop transition checker.
// Row index is {R,S,Qv}; r1..r8 map to 0..7.
package sr_ff_pkg;

  localparam logic [2:0] ROW_R1 = 3'd0;
  localparam logic [2:0] ROW_R2 = 3'd1;
  localparam logic [2:0] ROW_R3 = 3'd2;
  localparam logic [2:0] ROW_R4 = 3'd3;
  localparam logic [2:0] ROW_R5 = 3'd4;
  localparam logic [2:0] ROW_R6 = 3'd5;
  localparam logic [2:0] ROW_R7 = 3'd6;
  localparam logic [2:0] ROW_R8 = 3'd7;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] row;
    logic       meta;
    logic       err;
    logic       compl_err;
  } chk_t;

  // Returns {valid, q}; valid=0 for the R=S=1 don't-care rows.
  function automatic logic [1:0] expected_q(input logic r, input logic s, input logic qv);
    logic [1:0] res;
    unique case ({r, s})
      2'b00:   res = {1'b1, qv};
      2'b01:   res = 2'b11;
      2'b10:   res = 2'b10;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sr_ff_checker_sat_counter.sv
// Saturating up-counter accepting an increment of 0, 1 or 2 per clock.
// Sum is formed two bits wider so the clamp never sees a wrapped value.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

  logic [W+1:0] sum;

  always_comb begin
    sum = {2'b00, cnt} + {{W{1'b0}}, inc};
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (sum > MAX)
      cnt <= MAX[W-1:0];
    else
      cnt <= sum[W-1:0];
  end

endmodule

// File: rtl/sr_ff_checker.sv
// Monitor for an SR flip-flop: classifies each transition into one of the
// eight {R,S,Qv} rows, checks Qv+1 and Qbar, and tracks coverage and errors.
module sr_ff_checker
  import sr_ff_pkg::*;
#(
  parameter int ERR_W       = 8,
  parameter bit CHECK_COMPL = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Qbar,
  output logic [2:0]       ROW,
  output logic             ROW_VALID,
  output logic             ERR,
  output logic             COMPL_ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             META,
  output logic [7:0]       COV,
  output logic             COV_DONE
);

  state_t     state;
  logic       prev_s, prev_r, prev_q;
  logic [1:0] exp_q;
  chk_t       chk;
  logic [7:0] cov_nxt;
  logic [1:0] inc;

  // S/R held from the previous edge pair with Q sampled on this edge.
  always_comb begin
    exp_q         = expected_q(prev_r, prev_s, prev_q);
    chk.row       = {prev_r, prev_s, prev_q};
    chk.meta      = ~exp_q[1];
    chk.err       = exp_q[1] & (Q != exp_q[0]);
    chk.compl_err = CHECK_COMPL & exp_q[1] & (Qbar == Q);
    cov_nxt       = COV | (8'd1 << chk.row);
    inc           = 2'd0;
    if (state != INIT)
      inc = {1'b0, chk.err} + {1'b0, chk.compl_err};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= INIT;
      prev_s    <= 1'b0;
      prev_r    <= 1'b0;
      prev_q    <= 1'b0;
      ROW       <= 3'd0;
      ROW_VALID <= 1'b0;
      ERR       <= 1'b0;
      COMPL_ERR <= 1'b0;
      META      <= 1'b0;
      COV       <= 8'd0;
      COV_DONE  <= 1'b0;
    end else begin
      prev_s <= S;
      prev_r <= R;
      prev_q <= Q;
      case (state)
        INIT: begin
          ROW_VALID <= 1'b0;
          ERR       <= 1'b0;
          COMPL_ERR <= 1'b0;
          META      <= 1'b0;
          state     <= RUN;
        end
        RUN, FULL: begin
          ROW       <= chk.row;
          ROW_VALID <= 1'b1;
          ERR       <= chk.err;
          COMPL_ERR <= chk.compl_err;
          META      <= chk.meta;
          COV       <= cov_nxt;
          COV_DONE  <= &cov_nxt;
          if (&cov_nxt)
            state <= FULL;
        end
        default: state <= INIT;
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (inc),
    .cnt (ERR_CNT)
  );

endmodule

// File: tb/tb_sr_ff_checker.sv
// Bench for sr_ff_checker: directed scenarios plus random traffic, checked
// every cycle against a transition-table model on two DUT widths.
`timescale 1ns/1ps
module tb_sr_ff_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       S = 1'b0, R = 1'b0, Q = 1'b0, Qbar = 1'b1;

  logic [2:0] a_ROW, b_ROW;
  logic       a_ROW_VALID, b_ROW_VALID, a_ERR, b_ERR, a_COMPL_ERR, b_COMPL_ERR;
  logic       a_META, b_META, a_COV_DONE, b_COV_DONE;
  logic [7:0] a_ERR_CNT, a_COV, b_COV;
  logic [1:0] b_ERR_CNT;

  sr_ff_checker #(.ERR_W(8), .CHECK_COMPL(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .ROW(a_ROW), .ROW_VALID(a_ROW_VALID), .ERR(a_ERR), .COMPL_ERR(a_COMPL_ERR),
    .ERR_CNT(a_ERR_CNT), .META(a_META), .COV(a_COV), .COV_DONE(a_COV_DONE)
  );

  sr_ff_checker #(.ERR_W(2), .CHECK_COMPL(1'b1)) dut_b (
    .CLK(CLK), .RST(RST), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .ROW(b_ROW), .ROW_VALID(b_ROW_VALID), .ERR(b_ERR), .COMPL_ERR(b_COMPL_ERR),
    .ERR_CNT(b_ERR_CNT), .META(b_META), .COV(b_COV), .COV_DONE(b_COV_DONE)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int meta_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history since reset and the transition table as plain arithmetic.
  bit m_known = 0;
  int m_edges = 0;
  bit m_cov[8];
  int m_total = 0;
  int m_row = 0;
  bit m_rv = 0, m_err = 0, m_meta = 0, m_ce = 0;
  bit p_s = 0, p_r = 0, p_q = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_known = 1; m_edges = 0; m_total = 0; m_row = 0;
      m_rv = 0; m_err = 0; m_meta = 0; m_ce = 0;
      for (int i = 0; i < 8; i++) m_cov[i] = 0;
    end else if (m_known) begin
      if (m_edges == 0) begin
        m_rv = 0; m_err = 0; m_meta = 0; m_ce = 0;
      end else begin
        int want;
        m_row = 4 * p_r + 2 * p_s + p_q;
        m_rv = 1;
        m_cov[m_row] = 1;
        if (p_r && p_s) begin
          m_meta = 1; m_err = 0; m_ce = 0;
        end else begin
          want = p_s ? 1 : (p_r ? 0 : int'(p_q));
          m_meta = 0;
          m_err = (int'(Q) != want);
          m_ce = (Qbar == Q);
        end
        m_total += int'(m_err) + int'(m_ce);
      end
      p_s = S; p_r = R; p_q = Q;
      m_edges++;
    end
  end

  always @(negedge CLK) begin
    if (m_known) begin
      int covv;
      bit all;
      covv = 0; all = 1;
      for (int i = 0; i < 8; i++) begin
        covv += int'(m_cov[i]) << i;
        all &= m_cov[i];
      end
      chk("ROW", int'(a_ROW), m_row);
      chk("ROW_VALID", int'(a_ROW_VALID), int'(m_rv));
      chk("ERR", int'(a_ERR), int'(m_err));
      chk("META", int'(a_META), int'(m_meta));
      chk("COMPL_ERR", int'(a_COMPL_ERR), int'(m_ce));
      chk("ERR_CNT8", int'(a_ERR_CNT), (m_total > 255) ? 255 : m_total);
      chk("COV", int'(a_COV), covv);
      chk("COV_DONE", int'(a_COV_DONE), int'(all));
      chk("ERR_CNT2", int'(b_ERR_CNT), (m_total > 3) ? 3 : m_total);
      chk("ERR_W2", int'(b_ERR), int'(m_err));
      if (a_ERR) err_seen++;
      if (a_META) meta_seen++;
    end
  end

  // Stimulus side: a flip-flop model that drives Q one edge after S/R.
  bit ffq = 0, ls = 0, lr = 0;

  function automatic bit ff_next(input bit r, input bit s, input bit q);
    if (r && s) return 1'b1;
    if (s) return 1'b1;
    if (r) return 1'b0;
    return q;
  endfunction

  task automatic apply(input bit s, input bit r, input bit q, input bit qb);
    S = s; R = r; Q = q; Qbar = qb;
    @(posedge CLK);
    #2;
  endtask

  task automatic good(input bit s, input bit r);
    ffq = ff_next(lr, ls, ffq);
    ls = s; lr = r;
    apply(s, r, ffq, ~ffq);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ffq = 0; ls = 0; lr = 0;
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    RST = 1'b0;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    int exp4[5];
    exp4 = '{1, 2, 3, 3, 3};

    // Reset state
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    chk("rst_COV", int'(a_COV), 0);
    chk("rst_ERR_CNT", int'(a_ERR_CNT), 0);
    chk("rst_ROW_VALID", int'(a_ROW_VALID), 0);

    // Full row sweep with a correct flip-flop; (R,S) order from the plan
    err_seen = 0; meta_seen = 0;
    good(1'b0, 1'b1); good(1'b0, 1'b0); good(1'b1, 1'b0); good(1'b0, 1'b0);
    good(1'b1, 1'b0); good(1'b0, 1'b1); good(1'b1, 1'b1); good(1'b1, 1'b1);
    good(1'b0, 1'b0);
    settle();
    chk("sweep_COV", int'(a_COV), 255);
    chk("sweep_COV_DONE", int'(a_COV_DONE), 1);
    chk("sweep_ERR_CNT", int'(a_ERR_CNT), 0);
    chk("sweep_meta_pulses", meta_seen, 2);
    chk("sweep_err_pulses", err_seen, 0);

    // Stuck-at-0 under set
    do_reset();
    err_seen = 0;
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) apply(1'b1, 1'b0, 1'b0, 1'b1);
    chk("stuck_ROW", int'(a_ROW), 2);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    chk("stuck_ROW_last", int'(a_ROW), 2);
    settle();
    chk("stuck_ERR_CNT", int'(a_ERR_CNT), 3);
    chk("stuck_ERR_CNT_w2", int'(b_ERR_CNT), 3);
    chk("stuck_err_pulses", err_seen, 3);

    // Complement check on a hold row, then on a metastable row
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    chk("compl_hold_CE", int'(a_COMPL_ERR), 1);
    chk("compl_hold_ERR", int'(a_ERR), 0);
    chk("compl_hold_CNT", int'(a_ERR_CNT), 1);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    chk("compl_meta_CE", int'(a_COMPL_ERR), 0);
    chk("compl_meta_META", int'(a_META), 1);
    chk("compl_meta_CNT", int'(a_ERR_CNT), 1);

    // Saturation of the 2-bit counter
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b1);
      chk("sat_seq", int'(b_ERR_CNT), exp4[i]);
    end
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    chk("sat_pre2", int'(b_ERR_CNT), 2);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_double_w2", int'(b_ERR_CNT), 3);
    chk("sat_double_w8", int'(a_ERR_CNT), 4);

    // Partial coverage cleared by a mid-run reset
    do_reset();
    good(1'b0, 1'b0); good(1'b1, 1'b0); good(1'b0, 1'b0); good(1'b1, 1'b0); good(1'b0, 1'b0);
    settle();
    chk("part_COV", int'(a_COV), 8'h0F);
    do_reset();
    chk("part_rst_COV", int'(a_COV), 0);
    chk("part_rst_CNT", int'(a_ERR_CNT), 0);
    chk("part_rst_RV", int'(a_ROW_VALID), 0);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    chk("part_init_RV", int'(a_ROW_VALID), 0);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    chk("part_first_RV", int'(a_ROW_VALID), 1);

    // First edge after reset is never checked
    do_reset();
    apply(1'b1, 1'b0, 1'b1, 1'b0);
    chk("init_ERR", int'(a_ERR), 0);
    chk("init_RV", int'(a_ROW_VALID), 0);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    chk("second_ERR", int'(a_ERR), 1);

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int pick;
      pick = $urandom_range(0, 99);
      if (pick < 2) begin
        do_reset();
      end else if (pick < 60) begin
        good(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        bit rs, rr, rq, rqb;
        rs = 1'($urandom_range(0, 1));
        rr = 1'($urandom_range(0, 1));
        rq = 1'($urandom_range(0, 1));
        rqb = ($urandom_range(0, 7) == 0) ? rq : ~rq;
        ls = rs; lr = rr; ffq = rq;
        apply(rs, rr, rq, rqb);
      end
    end

    settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
